// File: rtl/gomoku_pkg.sv
// Shared gomoku definitions: board geometry, field widths, result codes,
// player encoding and the move-commit FSM state encoding.
package gomoku_pkg;

    localparam int unsigned BOARD_N = 15;
    localparam int unsigned CELLS   = BOARD_N * BOARD_N;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned RES_W   = 2;
    localparam int unsigned LAT_W   = 4;

    localparam logic [RES_W-1:0] RES_OK      = 2'd0;
    localparam logic [RES_W-1:0] RES_ILLEGAL = 2'd1;
    localparam logic [RES_W-1:0] RES_WIN     = 2'd2;
    localparam logic [RES_W-1:0] RES_DRAW    = 2'd3;

    localparam logic BLACK = 1'b0;
    localparam logic WHITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_VALIDATE = 3'd1,
        ST_WRITE    = 3'd2,
        ST_CHECK    = 3'd3,
        ST_RESULT   = 3'd4,
        ST_OVER     = 3'd5
    } state_e;

endpackage

// File: rtl/move_commit_ctrl_if.sv
// Move request / result handshake between the input/AI layer (master) and
// move_commit_ctrl (slave).
//   move_valid/move_row/move_col : request, master -> slave
//   move_ready                   : slave accepts when high (IDLE only)
//   result_valid/result_code     : one-cycle verdict per accepted request
interface move_commit_ctrl_if;
    import gomoku_pkg::*;

    logic               move_valid;
    logic               move_ready;
    logic [COORD_W-1:0] move_row;
    logic [COORD_W-1:0] move_col;
    logic               result_valid;
    logic [RES_W-1:0]   result_code;

    modport master (
        output move_valid, move_row, move_col,
        input  move_ready, result_valid, result_code
    );

    modport slave (
        input  move_valid, move_row, move_col,
        output move_ready, result_valid, result_code
    );

endinterface

// File: rtl/cell_index.sv
// Combinational (row, col) -> linear board index (row*BOARD_N + col) plus an
// in-range flag. Index is always computed in 8 bits; callers must gate any
// use of idx_o with in_range_o.
//   row_i, col_i : requested coordinates (0..15 representable)
//   idx_o        : linear index, <= 240 for any 4-bit input pair
//   in_range_o   : both coordinates < BOARD_N
module cell_index
    import gomoku_pkg::*;
(
    input  logic [COORD_W-1:0] row_i,
    input  logic [COORD_W-1:0] col_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               in_range_o
);

    assign idx_o      = IDX_W'(row_i) * IDX_W'(BOARD_N) + IDX_W'(col_i);
    assign in_range_o = (row_i < COORD_W'(BOARD_N)) && (col_i < COORD_W'(BOARD_N));

endmodule

// File: rtl/move_commit_ctrl.sv
// Write side of the gomoku board bitmap: validates move requests, commits
// stones into per-player 225-bit boards, hands the mover's board to an
// external win checker and reports OK / ILLEGAL / WIN / DRAW.
// Optional take-back of the last move is built when MOVE_UNDO_EN is defined.
//   clk, rst        : clock, synchronous active-high reset
//   mv              : move request / result handshake (slave side)
//   new_game, undo  : control pulses (undo only acts with MOVE_UNDO_EN)
//   black_board, white_board, cur_player, move_count, game_over : game state
//   chk_row, chk_col, chk_board, chk_req, chk_win : win-checker interface
module move_commit_ctrl
    import gomoku_pkg::*;
#(
    parameter int unsigned CHECK_LAT    = 1,
    parameter bit          FIRST_PLAYER = 1'b0
)
(
    input  logic               clk,
    input  logic               rst,
    move_commit_ctrl_if.slave  mv,
    input  logic               new_game,
    input  logic               undo,
    output logic [CELLS-1:0]   black_board,
    output logic [CELLS-1:0]   white_board,
    output logic               cur_player,
    output logic [COORD_W-1:0] chk_row,
    output logic [COORD_W-1:0] chk_col,
    output logic [CELLS-1:0]   chk_board,
    output logic               chk_req,
    input  logic               chk_win,
    output logic               game_over,
    output logic [CNT_W-1:0]   move_count
);

    localparam logic [CELLS-1:0] CELL_ONE = CELLS'(1);

    state_e             state_q;
    logic               ready_q;
    logic [COORD_W-1:0] row_q;
    logic [COORD_W-1:0] col_q;
    logic [CELLS-1:0]   black_q;
    logic [CELLS-1:0]   white_q;
    logic               player_q;
    logic [CNT_W-1:0]   count_q;
    logic [COORD_W-1:0] chk_row_q;
    logic [COORD_W-1:0] chk_col_q;
    logic [CELLS-1:0]   chk_board_q;
    logic               chk_req_q;
    logic [LAT_W-1:0]   chk_cnt_q;
    logic               res_vld_q;
    logic [RES_W-1:0]   res_code_q;
    logic               over_q;

    logic [IDX_W-1:0]   idx_c;
    logic               in_range_c;
    logic [CELLS-1:0]   wr_mask_c;
    logic               occupied_c;
    logic               new_game_c;

    // Index of the latched request
    cell_index u_cell_index (
        .row_i      (row_q),
        .col_i      (col_q),
        .idx_o      (idx_c),
        .in_range_o (in_range_c)
    );

    // Shifting past bit 224 yields zero, so an out-of-range index never hits a cell
    assign wr_mask_c  = CELL_ONE << idx_c;
    assign occupied_c = |((black_q | white_q) & wr_mask_c);
    assign new_game_c = new_game && ((state_q == ST_IDLE) || (state_q == ST_OVER));

`ifdef MOVE_UNDO_EN
    logic [IDX_W-1:0] last_idx_q;
    logic             last_player_q;
    logic             last_vld_q;
    logic [CELLS-1:0] undo_mask_c;
    logic             undo_take_c;

    assign undo_mask_c = CELL_ONE << last_idx_q;
    assign undo_take_c = undo && last_vld_q && (count_q != '0);
`else
    logic unused_undo;
    assign unused_undo = undo;
`endif

    // Move-commit FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst || new_game_c) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            row_q       <= '0;
            col_q       <= '0;
            black_q     <= '0;
            white_q     <= '0;
            player_q    <= FIRST_PLAYER;
            count_q     <= '0;
            chk_row_q   <= '0;
            chk_col_q   <= '0;
            chk_board_q <= '0;
            chk_req_q   <= 1'b0;
            chk_cnt_q   <= '0;
            res_vld_q   <= 1'b0;
            res_code_q  <= RES_OK;
            over_q      <= 1'b0;
`ifdef MOVE_UNDO_EN
            last_idx_q    <= '0;
            last_player_q <= BLACK;
            last_vld_q    <= 1'b0;
`endif
        end else begin
            res_vld_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (mv.move_valid) begin
                        row_q   <= mv.move_row;
                        col_q   <= mv.move_col;
                        ready_q <= 1'b0;
                        state_q <= ST_VALIDATE;
                    end
`ifdef MOVE_UNDO_EN
                    else if (undo_take_c) begin
                        if (last_player_q == BLACK) begin
                            black_q <= black_q & ~undo_mask_c;
                        end else begin
                            white_q <= white_q & ~undo_mask_c;
                        end
                        count_q    <= count_q - CNT_W'(1);
                        player_q   <= last_player_q;
                        last_vld_q <= 1'b0;
                        res_vld_q  <= 1'b1;
                        res_code_q <= RES_OK;
                        ready_q    <= 1'b0;
                        state_q    <= ST_RESULT;
                    end
`endif
                end

                ST_VALIDATE: begin
                    if (!in_range_c || occupied_c) begin
                        res_vld_q  <= 1'b1;
                        res_code_q <= RES_ILLEGAL;
                        state_q    <= ST_RESULT;
                    end else begin
                        state_q <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (player_q == BLACK) begin
                        black_q     <= black_q | wr_mask_c;
                        chk_board_q <= black_q | wr_mask_c;
                    end else begin
                        white_q     <= white_q | wr_mask_c;
                        chk_board_q <= white_q | wr_mask_c;
                    end
                    count_q   <= count_q + CNT_W'(1);
                    chk_row_q <= row_q;
                    chk_col_q <= col_q;
                    chk_req_q <= 1'b1;
                    chk_cnt_q <= '0;
                    state_q   <= ST_CHECK;
`ifdef MOVE_UNDO_EN
                    last_idx_q    <= idx_c;
                    last_player_q <= player_q;
                    last_vld_q    <= 1'b1;
`endif
                end

                ST_CHECK: begin
                    // Verdict sampled on the last of CHECK_LAT request cycles
                    if (chk_cnt_q == LAT_W'(CHECK_LAT - 1)) begin
                        chk_req_q <= 1'b0;
                        res_vld_q <= 1'b1;
                        state_q   <= ST_RESULT;
                        if (chk_win) begin
                            res_code_q <= RES_WIN;
                            over_q     <= 1'b1;
                        end else if (count_q == CNT_W'(CELLS)) begin
                            res_code_q <= RES_DRAW;
                            over_q     <= 1'b1;
                        end else begin
                            res_code_q <= RES_OK;
                            player_q   <= ~player_q;
                        end
                    end else begin
                        chk_cnt_q <= chk_cnt_q + LAT_W'(1);
                    end
                end

                ST_RESULT: begin
                    ready_q <= ~over_q;
                    state_q <= over_q ? ST_OVER : ST_IDLE;
                end

                ST_OVER: begin
                    ready_q <= 1'b0;
                end

                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mv.move_ready   = ready_q;
    assign mv.result_valid = res_vld_q;
    assign mv.result_code  = res_code_q;
    assign black_board     = black_q;
    assign white_board     = white_q;
    assign cur_player      = player_q;
    assign chk_row         = chk_row_q;
    assign chk_col         = chk_col_q;
    assign chk_board       = chk_board_q;
    assign chk_req         = chk_req_q;
    assign game_over       = over_q;
    assign move_count      = count_q;

endmodule

// File: tb/tb_move_commit_ctrl.sv
// Scoreboarded bench for move_commit_ctrl. Expected result codes are queued
// as moves are driven; a negedge monitor pops and compares them on every
// result_valid pulse. The win checker is a behavioural five-in-a-row model.
module tb_move_commit_ctrl;
    import gomoku_pkg::*;

    localparam int unsigned CHECK_LAT    = 1;
    localparam bit          FIRST_PLAYER = 1'b0;

    logic               clk = 1'b0;
    logic               rst;
    logic               new_game;
    logic               undo;
    logic [CELLS-1:0]   black_board;
    logic [CELLS-1:0]   white_board;
    logic               cur_player;
    logic [COORD_W-1:0] chk_row;
    logic [COORD_W-1:0] chk_col;
    logic [CELLS-1:0]   chk_board;
    logic               chk_req;
    logic               chk_win;
    logic               game_over;
    logic [CNT_W-1:0]   move_count;
    logic               force_nowin;

    int n_vec = 0;
    int n_err = 0;
    logic [RES_W-1:0] exp_q[$];

    move_commit_ctrl_if mv_if ();

    move_commit_ctrl #(
        .CHECK_LAT    (CHECK_LAT),
        .FIRST_PLAYER (FIRST_PLAYER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mv          (mv_if),
        .new_game    (new_game),
        .undo        (undo),
        .black_board (black_board),
        .white_board (white_board),
        .cur_player  (cur_player),
        .chk_row     (chk_row),
        .chk_col     (chk_col),
        .chk_board   (chk_board),
        .chk_req     (chk_req),
        .chk_win     (chk_win),
        .game_over   (game_over),
        .move_count  (move_count)
    );

    always #5 clk = ~clk;

    // Five-in-a-row through (r, c) on board b
    function automatic logic five(input logic [CELLS-1:0] b, input int r, input int c);
        int dr[4];
        int dc[4];
        dr = '{0, 1, 1, 1};
        dc = '{1, 0, 1, -1};
        for (int d = 0; d < 4; d++) begin
            int n = 1;
            for (int sgn = -1; sgn <= 1; sgn += 2) begin
                for (int k = 1; k < 5; k++) begin
                    int rr = r + sgn * k * dr[d];
                    int cc = c + sgn * k * dc[d];
                    if (rr < 0 || rr > 14 || cc < 0 || cc > 14) break;
                    if (!b[rr * 15 + cc]) break;
                    n++;
                end
            end
            if (n >= 5) return 1'b1;
        end
        return 1'b0;
    endfunction

    assign chk_win = force_nowin ? 1'b0 : five(chk_board, int'(chk_row), int'(chk_col));

    // Result scoreboard
    always @(negedge clk) begin
        if (!rst && mv_if.result_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got code %0d, none expected", mv_if.result_code);
            end else begin
                logic [RES_W-1:0] e;
                e = exp_q.pop_front();
                if (mv_if.result_code !== e) begin
                    n_err++;
                    $display("FAIL result_code: got %0d, expected %0d", mv_if.result_code, e);
                end
            end
        end
    end

    task automatic do_move(input logic [3:0] r, input logic [3:0] c, input logic [RES_W-1:0] code);
        int cyc = 0;
        int creq = 0;
        logic seen = 1'b0;
        int exp_lat = (code == RES_ILLEGAL) ? 2 : 3 + int'(CHECK_LAT);
        int exp_req = (code == RES_ILLEGAL) ? 0 : int'(CHECK_LAT);
        exp_q.push_back(code);
        @(negedge clk);
        mv_if.move_valid = 1'b1;
        mv_if.move_row   = r;
        mv_if.move_col   = c;
        @(posedge clk);
        #1 mv_if.move_valid = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (chk_req === 1'b1) creq++;
            if (mv_if.result_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            void'(exp_q.pop_back());
            $display("FAIL move_timeout (%0d,%0d): no result_valid within 40 cycles", r, c);
        end else if (cyc != exp_lat || creq != exp_req) begin
            n_err++;
            $display("FAIL move_latency (%0d,%0d): got lat %0d req %0d, expected lat %0d req %0d",
                     r, c, cyc, creq, exp_lat, exp_req);
        end
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_undo(input logic exp_pulse);
        logic seen = 1'b0;
        if (exp_pulse) exp_q.push_back(RES_OK);
        @(negedge clk);
        undo = 1'b1;
        @(posedge clk);
        #1 undo = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mv_if.result_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== exp_pulse) begin
            n_err++;
            $display("FAIL undo_pulse: got %0b, expected %0b", seen, exp_pulse);
        end
        if (exp_pulse && !seen) void'(exp_q.pop_back());
    endtask

    task automatic check_clean(input string tag);
        n_vec++;
        if (black_board !== '0 || white_board !== '0 || move_count !== 8'd0 ||
            cur_player !== FIRST_PLAYER || game_over !== 1'b0 || mv_if.move_ready !== 1'b1 ||
            mv_if.result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s: bcnt %0d wcnt %0d count %0d player %0b over %0b ready %0b rv %0b, expected all clear, player %0b, ready 1",
                     tag, $countones(black_board), $countones(white_board), move_count, cur_player,
                     game_over, mv_if.move_ready, mv_if.result_valid, FIRST_PLAYER);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_clean("reset_state");
        n_vec++;
        if (chk_req !== 1'b0 || chk_row !== 4'd0 || chk_col !== 4'd0 || chk_board !== '0 ||
            mv_if.result_code !== RES_OK) begin
            n_err++;
            $display("FAIL reset_chk: req %0b row %0d col %0d code %0d, expected zeros",
                     chk_req, chk_row, chk_col, mv_if.result_code);
        end
    endtask

    task automatic test_legal();
        do_move(4'd7, 4'd7, RES_OK);
        n_vec++;
        if (black_board[112] !== 1'b1 || $countones(black_board) != 1 || white_board !== '0 ||
            cur_player !== 1'b1 || move_count !== 8'd1) begin
            n_err++;
            $display("FAIL legal_7_7: b112 %0b bcnt %0d player %0b count %0d, expected 1 1 1 1",
                     black_board[112], $countones(black_board), cur_player, move_count);
        end
        n_vec++;
        if (chk_row !== 4'd7 || chk_col !== 4'd7 || chk_board[112] !== 1'b1) begin
            n_err++;
            $display("FAIL chk_outputs: row %0d col %0d bit %0b, expected 7 7 1",
                     chk_row, chk_col, chk_board[112]);
        end
    endtask

    task automatic test_illegal();
        logic [CELLS-1:0] b0, w0;
        b0 = black_board;
        w0 = white_board;
        do_move(4'd7, 4'd7, RES_ILLEGAL);
        do_move(4'd15, 4'd3, RES_ILLEGAL);
        do_move(4'd3, 4'd15, RES_ILLEGAL);
        n_vec++;
        if (black_board !== b0 || white_board !== w0 || move_count !== 8'd1 || cur_player !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_no_change: count %0d player %0b boards_same %0b, expected 1 1 1",
                     move_count, cur_player, (black_board === b0) && (white_board === w0));
        end
        do_move(4'd14, 4'd14, RES_OK);
        n_vec++;
        if (white_board[224] !== 1'b1 || move_count !== 8'd2 || cur_player !== 1'b0) begin
            n_err++;
            $display("FAIL corner_14_14: w224 %0b count %0d player %0b, expected 1 2 0",
                     white_board[224], move_count, cur_player);
        end
    endtask

    task automatic test_win();
        do_new_game();
        check_clean("new_game_idle");
        for (int i = 0; i < 4; i++) begin
            do_move(4'd0, 4'(i), RES_OK);
            do_move(4'd5, 4'(i), RES_OK);
        end
        do_move(4'd0, 4'd4, RES_WIN);
        @(negedge clk);
        n_vec++;
        if (game_over !== 1'b1 || cur_player !== 1'b0 || mv_if.move_ready !== 1'b0 || move_count !== 8'd9) begin
            n_err++;
            $display("FAIL win_state: over %0b player %0b ready %0b count %0d, expected 1 0 0 9",
                     game_over, cur_player, mv_if.move_ready, move_count);
        end
        // Requests and undo in OVER must be ignored
        @(negedge clk);
        mv_if.move_valid = 1'b1;
        mv_if.move_row   = 4'd10;
        mv_if.move_col   = 4'd10;
        undo             = 1'b1;
        repeat (3) @(negedge clk);
        mv_if.move_valid = 1'b0;
        undo             = 1'b0;
        repeat (6) @(negedge clk);
        n_vec++;
        if (move_count !== 8'd9 || black_board[160] !== 1'b0 || white_board[160] !== 1'b0 ||
            mv_if.move_ready !== 1'b0 || game_over !== 1'b1 || black_board[4] !== 1'b1) begin
            n_err++;
            $display("FAIL over_ignores: count %0d b160 %0b w160 %0b ready %0b over %0b b4 %0b, expected 9 0 0 0 1 1",
                     move_count, black_board[160], white_board[160], mv_if.move_ready, game_over, black_board[4]);
        end
    endtask

    task automatic test_draw();
        do_new_game();
        check_clean("new_game_over");
        force_nowin = 1'b1;
        for (int i = 0; i < 225; i++) begin
            do_move(4'(i / 15), 4'(i % 15), (i == 224) ? RES_DRAW : RES_OK);
        end
        n_vec++;
        if (move_count !== 8'd225 || game_over !== 1'b1 || $countones(black_board) != 113 ||
            $countones(white_board) != 112) begin
            n_err++;
            $display("FAIL draw_state: count %0d over %0b bcnt %0d wcnt %0d, expected 225 1 113 112",
                     move_count, game_over, $countones(black_board), $countones(white_board));
        end
        force_nowin = 1'b0;
        do_new_game();
        check_clean("new_game_after_draw");
    endtask

    task automatic test_rst_mid();
        logic hit = 1'b0;
        @(negedge clk);
        mv_if.move_valid = 1'b1;
        mv_if.move_row   = 4'd2;
        mv_if.move_col   = 4'd2;
        @(posedge clk);
        #1 mv_if.move_valid = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (chk_req === 1'b1) hit = 1'b1;
        end
        n_vec++;
        if (!hit) begin
            n_err++;
            $display("FAIL rst_mid_reach_check: chk_req never seen within 10 cycles");
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_clean("rst_mid_state");
        n_vec++;
        if (chk_req !== 1'b0 || chk_board !== '0 || chk_row !== 4'd0) begin
            n_err++;
            $display("FAIL rst_mid_chk: req %0b row %0d, expected 0 0", chk_req, chk_row);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_undo();
        do_move(4'd3, 4'd4, RES_OK);
        n_vec++;
        if (black_board[49] !== 1'b1 || cur_player !== 1'b1 || move_count !== 8'd1) begin
            n_err++;
            $display("FAIL undo_setup: b49 %0b player %0b count %0d, expected 1 1 1",
                     black_board[49], cur_player, move_count);
        end
`ifdef MOVE_UNDO_EN
        do_undo(1'b1);
        n_vec++;
        if (black_board[49] !== 1'b0 || cur_player !== 1'b0 || move_count !== 8'd0 ||
            mv_if.move_ready !== 1'b1) begin
            n_err++;
            $display("FAIL undo_effect: b49 %0b player %0b count %0d ready %0b, expected 0 0 0 1",
                     black_board[49], cur_player, move_count, mv_if.move_ready);
        end
        do_undo(1'b0);
        n_vec++;
        if (move_count !== 8'd0 || cur_player !== 1'b0) begin
            n_err++;
            $display("FAIL undo_second: count %0d player %0b, expected 0 0", move_count, cur_player);
        end
`else
        do_undo(1'b0);
        n_vec++;
        if (black_board[49] !== 1'b1 || cur_player !== 1'b1 || move_count !== 8'd1) begin
            n_err++;
            $display("FAIL undo_ignored: b49 %0b player %0b count %0d, expected 1 1 1",
                     black_board[49], cur_player, move_count);
        end
`endif
    endtask

    initial begin
        rst              = 1'b1;
        new_game         = 1'b0;
        undo             = 1'b0;
        force_nowin      = 1'b0;
        mv_if.move_valid = 1'b0;
        mv_if.move_row   = 4'd0;
        mv_if.move_col   = 4'd0;

        test_reset();
        test_legal();
        test_illegal();
        test_win();
        test_draw();
        test_rst_mid();
        test_undo();

        repeat (4) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected results never produced", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/move_commit_ctrl.md
Name: move_commit_ctrl

Overview:
- Write side of the gomoku board bitmap.
- Accepts move requests (row, col) from the input/AI layer, validates them, and commits stones into per-player 225-bit boards.
- Presents the mover's board plus (row, col) to the downstream win-check logic, samples its verdict, and reports a result code.
- Tracks side-to-move, move count, draw and game-over.

Parameters:
- BOARD_N, 15, board edge length; cells = BOARD_N*BOARD_N = 225; bit index = row*BOARD_N + col.
- CHECK_LAT, 1, cycles chk_req is held before chk_win is sampled; range 1..15.
- FIRST_PLAYER, 0, side to move after reset/new_game; 0 = black, 1 = white.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- new_game  in  1  pulse; clears both boards, count and game_over; honoured in IDLE or OVER only.
- move_valid  in  1  move request valid.
- move_ready  out  1  high only in IDLE; transfer occurs when move_valid & move_ready.
- move_row  in  4  requested row, 0..14.
- move_col  in  4  requested column, 0..14.
- undo  in  1  pulse; take back last move (UNDO_EN only).
- black_board  out  225  committed black stones.
- white_board  out  225  committed white stones.
- cur_player  out  1  side to move; 0 = black.
- chk_row  out  4  row handed to the win checker.
- chk_col  out  4  column handed to the win checker.
- chk_board  out  225  board of the player who just moved.
- chk_req  out  1  high while in CHECK.
- chk_win  in  1  checker verdict; combinational from chk_*.
- result_valid  out  1  one-cycle pulse per accepted transfer.
- result_code  out  2  0 = OK, 1 = ILLEGAL, 2 = WIN, 3 = DRAW; valid with result_valid.
- game_over  out  1  sticky after WIN or DRAW.
- move_count  out  8  stones on board, 0..225.

Behaviour:
- Reset values:
  - boards = 0, cur_player = FIRST_PLAYER, move_count = 0.
  - chk_* = 0, result_valid = 0, result_code = 0, game_over = 0.
  - state = IDLE, move_ready = 1 after the reset cycle.
- States: IDLE, VALIDATE, WRITE, CHECK, RESULT, OVER.
- IDLE:
  - On transfer, latch row/col, go to VALIDATE. move_ready drops the next cycle.
  - new_game has priority over move_valid, which has priority over undo.
- VALIDATE: one cycle.
  - Illegal if row > 14, col > 14, or the cell is set in either board.
  - Illegal → RESULT with code ILLEGAL; no state change, player not toggled.
  - Legal → WRITE.
- WRITE:
  - Set the index bit in the mover's board; move_count += 1.
  - Drive chk_row/chk_col/chk_board; go to CHECK.
- CHECK:
  - chk_req high for exactly CHECK_LAT cycles.
  - Sample chk_win on the last CHECK cycle.
- RESULT: single cycle, result_valid = 1.
  - win → code WIN, game_over = 1, next OVER; cur_player unchanged (still identifies the winner).
  - Else if move_count == 225 → DRAW, game_over = 1, next OVER.
  - Else → OK, toggle cur_player, next IDLE.
- OVER: move_ready = 0; move_valid and undo are ignored; new_game → IDLE.
- new_game takes effect on the next edge: same values as reset except that the state is IDLE.
- Total latency from transfer to result_valid: 3 + CHECK_LAT cycles; illegal moves take 2 cycles.
- Index arithmetic is computed in 8 bits (row*15 + col ≤ 224). The out-of-range check precedes indexing, so no out-of-range bit is ever written.
- chk_* outputs hold their last values outside CHECK.
- rst mid-operation abandons any in-flight move; no result is produced for it.

Optional Feature:
- Macro: MOVE_UNDO_EN.
- Defined:
  - Register the last committed index and mover.
  - undo pulse in IDLE with move_count > 0 and a valid last record: clear that bit, move_count -= 1, cur_player = that mover, invalidate the record (one level only).
  - result_valid pulses with code OK.
  - undo with no record: ignored, no pulse.
  - undo in OVER (after WIN/DRAW): ignored.
- Undefined: the undo port exists but is ignored; no extra registers.

Decomposition:
- Shared package gomoku_pkg:
  - BOARD_N and CELLS = 225.
  - Result-code constants RES_OK, RES_ILLEGAL, RES_WIN, RES_DRAW.
  - FSM state encoding.
  - Player constants BLACK = 0, WHITE = 1.
- One natural sub-module, cell_index: combinational (row, col) → 8-bit index plus in_range flag. Used here and reusable by display/AI logic.

Test Plan:
- Reset, then move (7,7) → after 4 cycles (CHECK_LAT = 1): result OK, black_board[112] = 1, cur_player = 1, move_count = 1.
- Move (7,7) again → ILLEGAL after 2 cycles; boards, count and player unchanged. Move (15,3) → ILLEGAL, no bit written.
- Black plays (0,0)..(0,4) interleaved with white (5,0)..(5,3); checker model asserts chk_win on the fifth black move → WIN, game_over = 1, cur_player = 0, move_ready = 0. A further move_valid is ignored.
- Fill 225 cells with checker model forcing chk_win = 0 → final result DRAW, move_count = 225. Then new_game → boards = 0, cur_player = FIRST_PLAYER, move_ready = 1.
- Assert rst during CHECK → no result_valid; all outputs at reset values next cycle.
- MOVE_UNDO_EN defined: play (3,4) as black, then undo → black_board[49] = 0, cur_player = 0, move_count = 0. A second undo produces no result_valid pulse.
